// File: rtl/fetch_queue_mw.sv
// Multi-width circular instruction fetch queue between fetch and decode/dispatch.
// Handles non-power-of-two depth, flush-with-refill, input clamping and sticky protocol-error flags.
module fetch_queue_mw #(
    parameter int IN_W    = 2,
    parameter int OUT_W   = 2,
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 32,
    localparam int IW = $clog2(IN_W + 1),
    localparam int OW = $clog2(OUT_W + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [IN_W*ENTRY_W-1:0]  in_data,
    input  logic [IW-1:0]            in_count,
    output logic [IW-1:0]            in_spots,
    input  logic                     flush,
    output logic [OUT_W*ENTRY_W-1:0] out_data,
    output logic [OW-1:0]            out_count,
    input  logic [OW-1:0]            deq_count,
    output logic [CW-1:0]            occupancy,
    output logic                     err_overflow,
    output logic                     err_underflow
);

    logic [ENTRY_W-1:0] storage_q [DEPTH];
    logic [PW-1:0]      head_q, head_d;
    logic [PW-1:0]      tail_q, tail_d;
    logic [CW-1:0]      occupancy_q, occupancy_d;
    logic               errOverflow_q, errOverflow_d;
    logic               errUnderflow_q, errUnderflow_d;

    int occI;
    int spots;
    int outCnt;
    int acc;
    int effDeq;

    function automatic int minI(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One extra bit of headroom plus conditional subtract keeps wrap correct for any DEPTH.
    function automatic logic [PW-1:0] ptrAdd(input logic [PW-1:0] p, input int n);
        logic [PW:0] s;
        s = (PW+1)'(p) + (PW+1)'(n);
        if (s >= (PW+1)'(DEPTH)) begin
            s = s - (PW+1)'(DEPTH);
        end
        return s[PW-1:0];
    endfunction

    always_comb begin
        occI   = int'(occupancy_q);
        spots  = flush ? minI(IN_W, DEPTH) : minI(IN_W, DEPTH - occI);
        outCnt = minI(occI, OUT_W);
        acc    = minI(int'(in_count), spots);
        effDeq = flush ? 0 : minI(int'(deq_count), outCnt);

        in_spots  = IW'(spots);
        out_count = OW'(outCnt);
        out_data  = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (i < outCnt) begin
                out_data[i*ENTRY_W +: ENTRY_W] = storage_q[ptrAdd(head_q, i)];
            end
        end

        // On flush the stored contents vanish but this cycle's refill from the corrected path survives.
        tail_d         = ptrAdd(tail_q, acc);
        head_d         = flush ? tail_q : ptrAdd(head_q, effDeq);
        occupancy_d    = flush ? CW'(acc) : CW'(occI + acc - effDeq);
        errOverflow_d  = errOverflow_q | (int'(in_count) > spots);
        errUnderflow_d = errUnderflow_q | (!flush && (int'(deq_count) > outCnt));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int d = 0; d < DEPTH; d++) begin
                storage_q[d] <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            occupancy_q    <= '0;
            errOverflow_q  <= 1'b0;
            errUnderflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < IN_W; i++) begin
                if (i < acc) begin
                    storage_q[ptrAdd(tail_q, i)] <= in_data[i*ENTRY_W +: ENTRY_W];
                end
            end
            head_q         <= head_d;
            tail_q         <= tail_d;
            occupancy_q    <= occupancy_d;
            errOverflow_q  <= errOverflow_d;
            errUnderflow_q <= errUnderflow_d;
        end
    end

    assign occupancy     = occupancy_q;
    assign err_overflow  = errOverflow_q;
    assign err_underflow = errUnderflow_q;

endmodule

// File: tb/tb_fetch_queue_mw.sv
// Directed bench for fetch_queue_mw with DEPTH=6, IN_W=4, OUT_W=3, 8-bit entries.
// Each step drives inputs, clocks once, then compares against hand-computed values.
module tb_fetch_queue_mw;

    localparam int IN_W    = 4;
    localparam int OUT_W   = 3;
    localparam int DEPTH   = 6;
    localparam int ENTRY_W = 8;
    localparam int IW      = $clog2(IN_W + 1);
    localparam int OW      = $clog2(OUT_W + 1);
    localparam int CW      = $clog2(DEPTH + 1);

    logic                     clock;
    logic                     reset;
    logic [IN_W*ENTRY_W-1:0]  in_data;
    logic [IW-1:0]            in_count;
    logic [IW-1:0]            in_spots;
    logic                     flush;
    logic [OUT_W*ENTRY_W-1:0] out_data;
    logic [OW-1:0]            out_count;
    logic [OW-1:0]            deq_count;
    logic [CW-1:0]            occupancy;
    logic                     err_overflow;
    logic                     err_underflow;

    int errors = 0;
    int checks = 0;

    fetch_queue_mw #(
        .IN_W(IN_W),
        .OUT_W(OUT_W),
        .DEPTH(DEPTH),
        .ENTRY_W(ENTRY_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_data(in_data),
        .in_count(in_count),
        .in_spots(in_spots),
        .flush(flush),
        .out_data(out_data),
        .out_count(out_count),
        .deq_count(deq_count),
        .occupancy(occupancy),
        .err_overflow(err_overflow),
        .err_underflow(err_underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's worth of inputs, clock them in, then return the inputs to idle.
    task automatic applyStimulus(input logic rst, input logic fl, input logic [IW-1:0] cnt,
                                 input logic [IN_W*ENTRY_W-1:0] data, input logic [OW-1:0] deq);
        reset     = rst;
        flush     = fl;
        in_count  = cnt;
        in_data   = data;
        deq_count = deq;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        flush     = 1'b0;
        in_count  = '0;
        in_data   = '0;
        deq_count = '0;
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_count  = '0;
        in_data   = '0;
        deq_count = '0;
        #2;

        // Reset state
        applyStimulus(1'b1, 1'b0, 3'd0, 32'h0, 2'd0);
        checkOutput("rst_occ",    32'(occupancy),     32'd0);
        checkOutput("rst_ocnt",   32'(out_count),     32'd0);
        checkOutput("rst_odata",  32'(out_data),      32'h0);
        checkOutput("rst_spots",  32'(in_spots),      32'd4);
        checkOutput("rst_eovf",   32'(err_overflow),  32'd0);
        checkOutput("rst_eunf",   32'(err_underflow), 32'd0);

        // Enqueue 1..4; nothing may appear on the outputs in the same cycle
        in_count = 3'd4;
        in_data  = 32'h04030201;
        #1;
        checkOutput("nobypass_ocnt", 32'(out_count), 32'd0);
        applyStimulus(1'b0, 1'b0, 3'd4, 32'h04030201, 2'd0);
        checkOutput("enq4_occ",   32'(occupancy), 32'd4);
        checkOutput("enq4_ocnt",  32'(out_count), 32'd3);
        checkOutput("enq4_odata", 32'(out_data),  32'h030201);
        checkOutput("enq4_spots", 32'(in_spots),  32'd2);

        // Wrap sequence: dequeue 3, enqueue 5..8, dequeue 3, dequeue 2
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 2'd3);
        checkOutput("wrap_d1_occ",   32'(occupancy), 32'd1);
        checkOutput("wrap_d1_odata", 32'(out_data),  32'h000004);
        applyStimulus(1'b0, 1'b0, 3'd4, 32'h08070605, 2'd0);
        checkOutput("wrap_e2_occ",   32'(occupancy), 32'd5);
        checkOutput("wrap_e2_odata", 32'(out_data),  32'h060504);
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 2'd3);
        checkOutput("wrap_d2_occ",   32'(occupancy), 32'd2);
        checkOutput("wrap_d2_ocnt",  32'(out_count), 32'd2);
        checkOutput("wrap_d2_odata", 32'(out_data),  32'h000807);
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 2'd2);
        checkOutput("wrap_d3_occ",   32'(occupancy),     32'd0);
        checkOutput("wrap_d3_ocnt",  32'(out_count),     32'd0);
        checkOutput("wrap_d3_odata", 32'(out_data),      32'h0);
        checkOutput("wrap_eovf",     32'(err_overflow),  32'd0);
        checkOutput("wrap_eunf",     32'(err_underflow), 32'd0);

        // Fill to DEPTH, then overflow attempt with simultaneous dequeue
        applyStimulus(1'b0, 1'b0, 3'd4, 32'h14131211, 2'd0);
        checkOutput("fill_spots2", 32'(in_spots), 32'd2);
        applyStimulus(1'b0, 1'b0, 3'd2, 32'h00001615, 2'd0);
        checkOutput("full_occ",   32'(occupancy), 32'd6);
        checkOutput("full_spots", 32'(in_spots),  32'd0);
        checkOutput("full_odata", 32'(out_data),  32'h131211);
        applyStimulus(1'b0, 1'b0, 3'd2, 32'h00002221, 2'd3);
        checkOutput("ovf_occ",   32'(occupancy),     32'd3);
        checkOutput("ovf_eovf",  32'(err_overflow),  32'd1);
        checkOutput("ovf_eunf",  32'(err_underflow), 32'd0);
        checkOutput("ovf_odata", 32'(out_data),      32'h161514);

        // Bring occupancy to 5, then flush with refill A,B and a dequeue request
        applyStimulus(1'b0, 1'b0, 3'd2, 32'h00003231, 2'd0);
        checkOutput("pre_flush_occ", 32'(occupancy), 32'd5);
        flush     = 1'b1;
        in_count  = 3'd2;
        in_data   = 32'h0000BBAA;
        deq_count = 2'd3;
        #1;
        checkOutput("flush_spots", 32'(in_spots), 32'd4);
        applyStimulus(1'b1 & 1'b0, 1'b1, 3'd2, 32'h0000BBAA, 2'd3);
        checkOutput("flush_occ",   32'(occupancy),     32'd2);
        checkOutput("flush_ocnt",  32'(out_count),     32'd2);
        checkOutput("flush_odata", 32'(out_data),      32'h00BBAA);
        checkOutput("flush_eunf",  32'(err_underflow), 32'd0);
        checkOutput("flush_eovf",  32'(err_overflow),  32'd1);

        // Underflow on empty queue is sticky until reset
        applyStimulus(1'b1, 1'b0, 3'd0, 32'h0, 2'd0);
        checkOutput("rst2_eovf", 32'(err_overflow), 32'd0);
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 2'd2);
        checkOutput("unf_eunf", 32'(err_underflow), 32'd1);
        checkOutput("unf_occ",  32'(occupancy),     32'd0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 2'd0);
        end
        checkOutput("unf_sticky", 32'(err_underflow), 32'd1);
        checkOutput("unf_occ10",  32'(occupancy),     32'd0);
        applyStimulus(1'b1, 1'b0, 3'd0, 32'h0, 2'd0);
        checkOutput("unf_clear", 32'(err_underflow), 32'd0);

        // Reset mid-operation beats a concurrent enqueue
        applyStimulus(1'b0, 1'b0, 3'd4, 32'h44434241, 2'd0);
        checkOutput("pre_rst_occ", 32'(occupancy), 32'd4);
        applyStimulus(1'b1, 1'b0, 3'd2, 32'h00005251, 2'd0);
        checkOutput("midrst_occ",   32'(occupancy), 32'd0);
        checkOutput("midrst_ocnt",  32'(out_count), 32'd0);
        checkOutput("midrst_odata", 32'(out_data),  32'h0);
        checkOutput("midrst_spots", 32'(in_spots),  32'd4);

        // Pointers restart at zero after reset
        applyStimulus(1'b0, 1'b0, 3'd1, 32'h00000061, 2'd0);
        checkOutput("post_rst_odata", 32'(out_data), 32'h000061);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
